// File: rtl/sr_latch_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_driver
// Purpose  : Writes one bit into an enabled SR latch cell and confirms the
//            write by reading the latch output back. The S/R/EN sequence is
//            setup -> enable pulse -> hold, so the cell never sees S=R=1 and
//            never sees an S/R edge while EN is high.
// Ports    : in_CLK   - clock, all state on the rising edge
//            in_RST   - asynchronous active-high reset
//            in_REQ   - write request, only honoured while idle
//            in_DATA  - bit to write, captured together with in_REQ
//            in_Q     - latch readback, compared directly (no synchronizer)
//            out_S    - latch set input
//            out_R    - latch reset input
//            out_EN   - latch enable
//            out_BUSY - high whenever a write is in progress
//            out_DONE - one-cycle completion pulse
//            out_ERR  - 1 when the last write timed out on readback mismatch
// Revision : 1.0 - initial release
// ============================================================================
module sr_latch_driver #(
    parameter int SETUP_CYC   = 1,
    parameter int PULSE_CYC   = 2,
    parameter int HOLD_CYC    = 1,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic in_CLK,
    input  logic in_RST,
    input  logic in_REQ,
    input  logic in_DATA,
    input  logic in_Q,
    output logic out_S,
    output logic out_R,
    output logic out_EN,
    output logic out_BUSY,
    output logic out_DONE,
    output logic out_ERR
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_HT  = (HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_SP > MAX_HT) ? MAX_SP : MAX_HT;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Counter reload values: a phase lasting N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_VERIFY = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_q, tgt_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             drive_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_REQ) begin
                    tgt_d   = in_DATA;
                    err_d   = 1'b0;
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_VERIFY;
                    cnt_d   = TIMEOUT_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_VERIFY: begin
                // A match ends the write at once; otherwise the counter
                // measures consecutive mismatches until the timeout.
                if (in_Q == tgt_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state:
        // the latch pins then change exactly on the state-change edge.
        drive_d = (state_d == ST_SETUP) || (state_d == ST_PULSE) ||
                  (state_d == ST_HOLD);
        s_d     = drive_d & tgt_d;
        r_d     = drive_d & ~tgt_d;
        en_d    = (state_d == ST_PULSE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Asynchronous reset withdraws EN immediately, even mid-pulse.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            tgt_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out_S    = s_q;
    assign out_R    = r_q;
    assign out_EN   = en_q;
    assign out_BUSY = busy_q;
    assign out_DONE = done_q;
    assign out_ERR  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_latch_driver
// Purpose  : Self-checking bench for sr_latch_driver. Instance A uses the
//            default timing and is compared every cycle against a
//            cycle-count model of the write sequence; instance B uses
//            3/4/2/5 timing and is checked for the latch-safety rules and
//            the exact best-case latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_latch_driver;

    localparam int SA = 1, PA = 2, HA = 1, TA = 8;
    localparam int SB = 3, PB = 4, HB = 2, TB = 5;
    localparam int DRV_A = SA + PA + HA;
    localparam int LAT_B = SB + PB + HB + 1;

    logic in_CLK  = 1'b0;
    logic in_RST  = 1'b0;
    logic in_REQ  = 1'b0;
    logic in_DATA = 1'b0;

    // Latch cell models plus a stuck-at override for A's readback.
    logic lq_a = 1'b0, lq_b = 1'b0;
    logic stuck = 1'b0, stuck_val = 1'b0;
    logic a_q;

    logic a_s, a_r, a_en, a_busy, a_done, a_err;
    logic b_s, b_r, b_en, b_busy, b_done, b_err;

    int   vectors     = 0;
    int   miscompares = 0;
    logic chk_en      = 1'b0;

    always #5 in_CLK = ~in_CLK;

    assign a_q = stuck ? stuck_val : lq_a;

    sr_latch_driver #(
        .SETUP_CYC(SA), .PULSE_CYC(PA), .HOLD_CYC(HA), .TIMEOUT_CYC(TA)
    ) u_dut_a (
        .in_CLK(in_CLK), .in_RST(in_RST), .in_REQ(in_REQ), .in_DATA(in_DATA),
        .in_Q(a_q), .out_S(a_s), .out_R(a_r), .out_EN(a_en),
        .out_BUSY(a_busy), .out_DONE(a_done), .out_ERR(a_err)
    );

    sr_latch_driver #(
        .SETUP_CYC(SB), .PULSE_CYC(PB), .HOLD_CYC(HB), .TIMEOUT_CYC(TB)
    ) u_dut_b (
        .in_CLK(in_CLK), .in_RST(in_RST), .in_REQ(in_REQ), .in_DATA(in_DATA),
        .in_Q(lq_b), .out_S(b_s), .out_R(b_r), .out_EN(b_en),
        .out_BUSY(b_busy), .out_DONE(b_done), .out_ERR(b_err)
    );

    // Transparent-while-enabled SR cell; updating mid-cycle is enough since
    // the readback is only sampled on later rising edges.
    always @(negedge in_CLK) begin
        if (a_en) lq_a <= a_s ? 1'b1 : (a_r ? 1'b0 : lq_a);
        if (b_en) lq_b <= b_s ? 1'b1 : (b_r ? 1'b0 : lq_b);
    end

    // ---------------- behavioural model of instance A ----------------------
    // m_t is the cycle number within the write (1 = first setup cycle);
    // the phase follows from plain range comparisons on m_t.
    logic m_busy = 1'b0, m_tgt = 1'b0, m_err = 1'b0, m_done = 1'b0;
    int   m_t    = 0;

    always @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            m_busy <= 1'b0; m_t <= 0; m_tgt <= 1'b0;
            m_err  <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (in_REQ) begin
                    m_busy <= 1'b1; m_t <= 1; m_tgt <= in_DATA; m_err <= 1'b0;
                end
            end else if (m_t > DRV_A && a_q == m_tgt) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_err <= 1'b0;
            end else if (m_t - DRV_A == TA) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_err <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    logic e_s, e_r, e_en;
    assign e_s  = m_busy && (m_t <= DRV_A) && m_tgt;
    assign e_r  = m_busy && (m_t <= DRV_A) && !m_tgt;
    assign e_en = m_busy && (m_t > SA) && (m_t <= SA + PA);

    // Per-cycle comparison of A against the model.
    initial begin
        forever begin
            @(negedge in_CLK);
            if (chk_en && !in_RST) begin
                vectors++;
                if ({a_s, a_r, a_en, a_busy, a_done, a_err} !==
                    {e_s, e_r, e_en, m_busy, m_done, m_err}) begin
                    miscompares++;
                    $display("FAIL model_cmp t=%0t: S R EN BUSY DONE ERR got %b%b%b%b%b%b expected %b%b%b%b%b%b",
                             $time, a_s, a_r, a_en, a_busy, a_done, a_err,
                             e_s, e_r, e_en, m_busy, m_done, m_err);
                end
            end
        end
    end

    // ---------------- instance B: safety rules and latency -----------------
    int   cyc    = 0;
    int   b_acc  = 0;
    logic b_pend = 1'b0;
    logic pb_s = 1'b0, pb_r = 1'b0, pb_en = 1'b0;

    initial begin
        forever begin
            @(posedge in_CLK);
            cyc++;
            if (!in_RST && !b_busy && in_REQ) begin
                b_acc  = cyc;
                b_pend = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge in_CLK);
            if (in_RST) begin
                b_pend = 1'b0;
                pb_s = 1'b0; pb_r = 1'b0; pb_en = 1'b0;
            end else if (chk_en) begin
                check("b_s_and_r", b_s & b_r, 1'b0);
                if (b_s !== pb_s || b_r !== pb_r)
                    check("b_sr_edge_while_en", pb_en | b_en, 1'b0);
                if (b_done) begin
                    check("b_done_without_req", b_pend, 1'b1);
                    check("b_err", b_err, 1'b0);
                    vectors++;
                    if (cyc - b_acc != LAT_B) begin
                        miscompares++;
                        $display("FAIL b_latency: got %0d expected %0d", cyc - b_acc, LAT_B);
                    end
                    b_pend = 1'b0;
                end
                pb_s = b_s; pb_r = b_r; pb_en = b_en;
            end
        end
    end

    // ---------------- directed stimulus ------------------------------------
    task automatic tick;
        @(posedge in_CLK);
        #1;
    endtask

    initial begin
        // Reset asserted between edges must clear outputs without a clock.
        #2 in_RST = 1'b1;
        #1;
        check("rst_S", a_s, 1'b0);       check("rst_R", a_r, 1'b0);
        check("rst_EN", a_en, 1'b0);     check("rst_BUSY", a_busy, 1'b0);
        check("rst_DONE", a_done, 1'b0); check("rst_ERR", a_err, 1'b0);
        tick; tick;
        #2 in_RST = 1'b0;
        chk_en = 1'b1;
        tick; tick; tick;
        check("idle_BUSY", a_busy, 1'b0);
        check("idle_S", a_s, 1'b0);

        // Write 1 with a working latch: cycle-by-cycle literal expectations.
        in_REQ = 1'b1; in_DATA = 1'b1; tick; in_REQ = 1'b0;
        check("w1_c1_S", a_s, 1'b1);     check("w1_c1_R", a_r, 1'b0);
        check("w1_c1_EN", a_en, 1'b0);   check("w1_c1_BUSY", a_busy, 1'b1);
        tick; check("w1_c2_EN", a_en, 1'b1);
        tick; check("w1_c3_EN", a_en, 1'b1);
        tick; check("w1_c4_EN", a_en, 1'b0); check("w1_c4_S", a_s, 1'b1);
        tick; check("w1_c5_S", a_s, 1'b0);   check("w1_c5_DONE", a_done, 1'b0);
        check("w1_c5_BUSY", a_busy, 1'b1);
        tick; check("w1_c6_DONE", a_done, 1'b1); check("w1_c6_ERR", a_err, 1'b0);
        check("w1_c6_BUSY", a_busy, 1'b0);       check("w1_Q", a_q, 1'b1);
        tick; check("w1_c7_DONE", a_done, 1'b0);

        // Write 0.
        in_REQ = 1'b1; in_DATA = 1'b0; tick; in_REQ = 1'b0;
        check("w0_R", a_r, 1'b1); check("w0_S", a_s, 1'b0);
        repeat (5) tick;
        check("w0_DONE", a_done, 1'b1); check("w0_ERR", a_err, 1'b0);
        check("w0_Q", a_q, 1'b0);
        tick;

        // Stuck readback: eight verify cycles, then DONE with ERR.
        stuck = 1'b1; stuck_val = 1'b0;
        in_REQ = 1'b1; in_DATA = 1'b1; tick; in_REQ = 1'b0;
        repeat (11) tick;
        check("stuck_c12_BUSY", a_busy, 1'b1); check("stuck_c12_DONE", a_done, 1'b0);
        tick;
        check("stuck_DONE", a_done, 1'b1); check("stuck_ERR", a_err, 1'b1);
        check("stuck_BUSY", a_busy, 1'b0);
        repeat (3) tick;
        check("stuck_ERR_held", a_err, 1'b1);
        stuck = 1'b0;

        // New request clears ERR; requests while busy are ignored.
        in_REQ = 1'b1; in_DATA = 1'b1; tick;
        check("clr_ERR", a_err, 1'b0);
        in_DATA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("busy_ignore_S", a_s, 1'b1);
            check("busy_ignore_R", a_r, 1'b0);
        end
        tick; tick;
        check("b2b_DONE", a_done, 1'b1);
        tick; in_REQ = 1'b0;
        check("b2b_R", a_r, 1'b1); check("b2b_BUSY", a_busy, 1'b1);
        repeat (5) tick;
        check("b2b_done2", a_done, 1'b1);
        tick;

        // Reset in the middle of the enable pulse.
        in_REQ = 1'b1; in_DATA = 1'b1; tick; in_REQ = 1'b0;
        tick;
        check("mid_EN_before", a_en, 1'b1);
        #2 in_RST = 1'b1;
        #1;
        check("mid_EN", a_en, 1'b0); check("mid_S", a_s, 1'b0);
        check("mid_R", a_r, 1'b0);   check("mid_BUSY", a_busy, 1'b0);
        tick;
        #3 in_RST = 1'b0;
        repeat (6) tick;
        check("mid_no_DONE", a_done, 1'b0);
        in_REQ = 1'b1; in_DATA = 1'b0; tick; in_REQ = 1'b0;
        repeat (5) tick;
        check("after_rst_DONE", a_done, 1'b1); check("after_rst_ERR", a_err, 1'b0);
        tick;

        // Random sweep; the model and the B checks watch every cycle.
        for (int c = 0; c < 1000; c++) begin
            if (c % 64 == 0) begin
                stuck     = ($urandom_range(0, 3) == 0);
                stuck_val = 1'($urandom_range(0, 1));
            end
            in_REQ  = ($urandom_range(0, 3) == 0);
            in_DATA = 1'($urandom_range(0, 1));
            tick;
        end
        in_REQ = 1'b0; stuck = 1'b0;
        repeat (25) tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
